// File: rtl/mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: opcodes, FSM states, cycle defaults.
package mdu_pkg;

  localparam logic [3:0] MDU_OP_NONE  = 4'd0;
  localparam logic [3:0] MDU_OP_MULT  = 4'd1;
  localparam logic [3:0] MDU_OP_MULTU = 4'd2;
  localparam logic [3:0] MDU_OP_DIV   = 4'd3;
  localparam logic [3:0] MDU_OP_DIVU  = 4'd4;
  localparam logic [3:0] MDU_OP_MFHI  = 4'd5;
  localparam logic [3:0] MDU_OP_MFLO  = 4'd6;
  localparam logic [3:0] MDU_OP_MTHI  = 4'd7;
  localparam logic [3:0] MDU_OP_MTLO  = 4'd8;

  localparam int unsigned DEFAULT_MULT_CYCLES = 5;
  localparam int unsigned DEFAULT_DIV_CYCLES  = 10;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } mdu_state_e;

endpackage

// File: rtl/mdu_divider.sv
// Combinational 32-bit divider: signed (truncating) or unsigned quotient/remainder, flags b == 0.
module mdu_divider (
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        isSigned,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        divByZero
);

  logic        negDividend;
  logic        negDivisor;
  logic [31:0] magA;
  logic [31:0] magB;
  logic [31:0] magQ;
  logic [31:0] magR;

  always_comb begin
    negDividend = isSigned && dividend[31];
    negDivisor  = isSigned && divisor[31];
    magA        = negDividend ? (32'd0 - dividend) : dividend;
    magB        = negDivisor ? (32'd0 - divisor) : divisor;
    divByZero   = (divisor == 32'd0);
    magQ        = divByZero ? 32'd0 : (magA / magB);
    magR        = divByZero ? 32'd0 : (magA % magB);
    // Remainder follows the dividend's sign; 0x80000000 / -1 wraps back to 0x80000000.
    quotient    = (negDividend ^ negDivisor) ? (32'd0 - magQ) : magQ;
    remainder   = negDividend ? (32'd0 - magR) : magR;
  end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle MIPS multiply/divide unit owning HI/LO.
// Define MDU_FAST_MULT_EN to retire mult/multu at the start edge with no busy cycles.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = DEFAULT_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        start,
  output logic        busy,
  output logic [31:0] mdu_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  mdu_state_e  state;
  logic [CntW-1:0] count;
  logic [31:0] pendingHi;
  logic [31:0] pendingLo;
  logic        pendingWrite;

  logic        isMultOp;
  logic        isDivOp;
  logic [63:0] prodS;
  logic [63:0] prodU;
  logic [63:0] product;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        divByZero;

  mdu_divider u_divider (
    .dividend  (src_a),
    .divisor   (src_b),
    .isSigned  (mdu_op == MDU_OP_DIV),
    .quotient  (quotient),
    .remainder (remainder),
    .divByZero (divByZero)
  );

  always_comb begin
    isMultOp = (mdu_op == MDU_OP_MULT) || (mdu_op == MDU_OP_MULTU);
    isDivOp  = (mdu_op == MDU_OP_DIV) || (mdu_op == MDU_OP_DIVU);
    start    = op_valid && (isMultOp || isDivOp) && !busy;
    // Low 64 bits of a 64x64 product are exact for sign-extended operands.
    prodS    = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
    prodU    = {32'd0, src_a} * {32'd0, src_b};
    product  = (mdu_op == MDU_OP_MULT) ? prodS : prodU;
    if (mdu_op == MDU_OP_MFHI) begin
      mdu_out = hi;
    end else if (mdu_op == MDU_OP_MFLO) begin
      mdu_out = lo;
    end else begin
      mdu_out = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= StIdle;
      busy         <= 1'b0;
      count        <= '0;
      hi           <= 32'd0;
      lo           <= 32'd0;
      pendingHi    <= 32'd0;
      pendingLo    <= 32'd0;
      pendingWrite <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (start) begin
            if (isMultOp) begin
`ifdef MDU_FAST_MULT_EN
              hi <= product[63:32];
              lo <= product[31:0];
`else
              pendingHi    <= product[63:32];
              pendingLo    <= product[31:0];
              pendingWrite <= 1'b1;
              count        <= CntW'(MULT_CYCLES);
              state        <= StRun;
              busy         <= 1'b1;
`endif
            end else begin
              pendingHi    <= remainder;
              pendingLo    <= quotient;
              pendingWrite <= !divByZero;
              count        <= CntW'(DIV_CYCLES);
              state        <= StRun;
              busy         <= 1'b1;
            end
          end else if (op_valid && (mdu_op == MDU_OP_MTHI)) begin
            hi <= src_a;
          end else if (op_valid && (mdu_op == MDU_OP_MTLO)) begin
            lo <= src_a;
          end
        end
        StRun: begin
          if (count == CntW'(1)) begin
            if (pendingWrite) begin
              hi <= pendingHi;
              lo <= pendingLo;
            end
            count <= '0;
            state <= StIdle;
            busy  <= 1'b0;
          end else begin
            count <= count - CntW'(1);
          end
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed literal cases plus randomized traffic vs a
// behavioural HI/LO model. Honours MDU_FAST_MULT_EN for the expected multiply latency.
module tb_mdu_unit;
  import mdu_pkg::*;

  localparam int unsigned MultCyc = 5;
  localparam int unsigned DivCyc  = 10;
`ifdef MDU_FAST_MULT_EN
  localparam int MultLat = 0;
`else
  localparam int MultLat = MultCyc;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [3:0]  mdu_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        start;
  logic        busy;
  logic [31:0] mdu_out;
  logic [31:0] hi;
  logic [31:0] lo;

  int vectors     = 0;
  int miscompares = 0;
  int violations  = 0;
  bit checkEn     = 1'b0;

  // Behavioural model: architectural HI/LO plus a countdown to a scheduled result.
  logic [31:0] mHi = 32'd0;
  logic [31:0] mLo = 32'd0;
  logic [31:0] mPendHi = 32'd0;
  logic [31:0] mPendLo = 32'd0;
  bit          mPendWrite = 1'b0;
  int          mLeft = 0;

  mdu_unit #(
    .MULT_CYCLES (MultCyc),
    .DIV_CYCLES  (DivCyc)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .op_valid (op_valid),
    .mdu_op   (mdu_op),
    .src_a    (src_a),
    .src_b    (src_b),
    .start    (start),
    .busy     (busy),
    .mdu_out  (mdu_out),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic schedule(logic [31:0] rHi, logic [31:0] rLo, bit wr, int lat);
    if (lat == 0) begin
      if (wr) begin
        mHi = rHi;
        mLo = rLo;
      end
    end else begin
      mPendHi    = rHi;
      mPendLo    = rLo;
      mPendWrite = wr;
      mLeft      = lat;
    end
  endtask

  task automatic modelStep();
    longint      sa, sb, sq, sr;
    logic [63:0] p;
    sa = $signed(src_a);
    sb = $signed(src_b);
    if (reset) begin
      mHi = 0; mLo = 0; mPendHi = 0; mPendLo = 0; mPendWrite = 0; mLeft = 0;
    end else if (mLeft > 0) begin
      if (op_valid && (mdu_op inside {[MDU_OP_MULT:MDU_OP_DIVU], MDU_OP_MTHI, MDU_OP_MTLO}))
        violations++;
      if (mLeft == 1 && mPendWrite) begin
        mHi = mPendHi;
        mLo = mPendLo;
      end
      mLeft--;
    end else if (op_valid) begin
      case (mdu_op)
        MDU_OP_MULT: begin
          p = sa * sb;
          schedule(p[63:32], p[31:0], 1'b1, MultLat);
        end
        MDU_OP_MULTU: begin
          p = {32'd0, src_a} * {32'd0, src_b};
          schedule(p[63:32], p[31:0], 1'b1, MultLat);
        end
        MDU_OP_DIV: begin
          if (sb == 0) schedule(0, 0, 1'b0, DivCyc);
          else begin
            sq = sa / sb;
            sr = sa % sb;
            schedule(sr[31:0], sq[31:0], 1'b1, DivCyc);
          end
        end
        MDU_OP_DIVU: begin
          if (src_b == 0) schedule(0, 0, 1'b0, DivCyc);
          else schedule(src_a % src_b, src_a / src_b, 1'b1, DivCyc);
        end
        MDU_OP_MTHI: mHi = src_a;
        MDU_OP_MTLO: mLo = src_a;
        default: ;
      endcase
    end
  endtask

  initial forever begin
    @(posedge clk);
    modelStep();
  end

  // Compare process: every settled cycle, all outputs against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      logic        expStart;
      logic [31:0] expOut;
      expStart = op_valid && (mdu_op inside {[MDU_OP_MULT:MDU_OP_DIVU]}) && (mLeft == 0);
      expOut   = (mdu_op == MDU_OP_MFHI) ? mHi : (mdu_op == MDU_OP_MFLO) ? mLo : 32'd0;
      check("busy", {31'd0, busy}, {31'd0, mLeft > 0});
      check("start", {31'd0, start}, {31'd0, expStart});
      check("mdu_out", mdu_out, expOut);
      check("hi", hi, mHi);
      check("lo", lo, mLo);
    end
  end

  task automatic drive(bit v, logic [3:0] op, logic [31:0] a, logic [31:0] b);
    @(posedge clk);
    #2;
    op_valid = v;
    mdu_op   = op;
    src_a    = a;
    src_b    = b;
  endtask

  // Idles until busy drops; checks the number of busy cycles seen (bounded).
  task automatic waitIdle(string name, int expCycles);
    int n;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      drive(1'b0, MDU_OP_NONE, 32'd0, 32'd0);
      if (!busy) break;
      n++;
    end
    check({name, "_busy_cycles"}, n, expCycles);
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 9))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int v0;
    reset = 1'b1; op_valid = 1'b0; mdu_op = MDU_OP_NONE; src_a = 0; src_b = 0;
    repeat (2) @(posedge clk);
    #2;
    reset   = 1'b0;
    checkEn = 1'b1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);

    // Signed multiply: -2 * 3.
    drive(1'b1, MDU_OP_MULT, 32'hFFFF_FFFE, 32'd3);
    #1 check("mult_start", {31'd0, start}, 32'd1);
    waitIdle("mult", MultLat);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);
    drive(1'b1, MDU_OP_MFLO, 32'd0, 32'd0);
    #1 check("mflo_out", mdu_out, 32'hFFFF_FFFA);

    drive(1'b1, MDU_OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    waitIdle("multu", MultLat);
    check("multu_hi", hi, 32'd1);
    check("multu_lo", lo, 32'hFFFF_FFFE);

    drive(1'b1, MDU_OP_DIV, 32'hFFFF_FFF9, 32'd2);
    waitIdle("div", DivCyc);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    // Divide by zero leaves HI/LO untouched.
    drive(1'b1, MDU_OP_MTHI, 32'h1234_5678, 32'd0);
    drive(1'b1, MDU_OP_MTLO, 32'h9ABC_DEF0, 32'd0);
    drive(1'b1, MDU_OP_DIVU, 32'd77, 32'd0);
    waitIdle("divz", DivCyc);
    check("divz_hi", hi, 32'h1234_5678);
    check("divz_lo", lo, 32'h9ABC_DEF0);

    drive(1'b1, MDU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    waitIdle("ovf", DivCyc);
    check("ovf_lo", lo, 32'h8000_0000);
    check("ovf_hi", hi, 32'd0);

    // Reset in busy cycle 4 abandons the divide.
    drive(1'b1, MDU_OP_MTHI, 32'hCAFE_F00D, 32'd0);
    drive(1'b1, MDU_OP_DIV, 32'd100, 32'd7);
    repeat (3) drive(1'b0, MDU_OP_NONE, 32'd0, 32'd0);
    drive(1'b0, MDU_OP_NONE, 32'd0, 32'd0);
    reset = 1'b1;
    drive(1'b0, MDU_OP_NONE, 32'd0, 32'd0);
    reset = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    repeat (12) drive(1'b0, MDU_OP_NONE, 32'd0, 32'd0);
    check("rst_hi_late", hi, 32'd0);
    check("rst_lo_late", lo, 32'd0);

    // Bubble carrying a MULT opcode does nothing.
    drive(1'b0, MDU_OP_MULT, 32'd3, 32'd4);
    #1 check("bubble_start", {31'd0, start}, 32'd0);
    drive(1'b0, MDU_OP_NONE, 32'd0, 32'd0);
    check("bubble_busy", {31'd0, busy}, 32'd0);

    // MTLO while busy is ignored and flagged by the hazard monitor.
    v0 = violations;
    drive(1'b1, MDU_OP_DIVU, 32'd20, 32'd3);
    drive(1'b1, MDU_OP_MTLO, 32'hDEAD_BEEF, 32'd0);
    waitIdle("mtbusy", DivCyc - 1);
    check("mtbusy_flag", violations, v0 + 1);
    check("mtbusy_lo", lo, 32'd6);
    check("mtbusy_hi", hi, 32'd2);

    // Randomized traffic honouring the hazard stall.
    for (int i = 0; i < 1500; i++) begin
      logic [3:0] op;
      bit         v;
      @(posedge clk);
      #2;
      v  = ($urandom_range(0, 7) != 0);
      op = 4'($urandom_range(0, 15));
      if (busy && v && (op inside {[MDU_OP_MULT:MDU_OP_DIVU], MDU_OP_MTHI, MDU_OP_MTLO}))
        op = ($urandom_range(0, 1) != 0) ? MDU_OP_MFHI : MDU_OP_MFLO;
      reset    = ($urandom_range(0, 299) == 0);
      op_valid = v;
      mdu_op   = op;
      src_a    = pickOperand();
      src_b    = pickOperand();
    end
    drive(1'b0, MDU_OP_NONE, 32'd0, 32'd0);
    reset = 1'b0;
    repeat (2) drive(1'b0, MDU_OP_NONE, 32'd0, 32'd0);

    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
